store_trace_monitor: RTL and testbench
======================================

Name: store_trace_monitor

Overview:
- Sits directly downstream of the multicycle ARM top; consumes its memory-write bus (MemWrite, Adr, WriteData) every clock.
- Captures each store into a small FIFO for draining by a host/bench interface.
- Runs a pass/fail state machine: pass on a store of SUCCESS_DATA to SUCCESS_ADR, fail on cycle timeout.
- Synthesizable replacement for the bench-side success check, usable on FPGA.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
SUCCESS_ADR, 32'd100, store address that signals program success
SUCCESS_DATA, 32'd8, store data that signals program success
MAX_CYCLES, 1000, cycles in RUN before declaring failure
CNT_W, 16, width of cycle counter (must hold MAX_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
MemWrite  in  1  store strobe from the processor, one cycle per store
Adr  in  32  store address
WriteData  in  32  store data
deq_ready  in  1  consumer accepts head entry
deq_valid  out  1  FIFO non-empty
deq_adr  out  32  head entry address
deq_data  out  32  head entry data
count  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a store was dropped because FIFO full
pass  out  1  program reached success store
fail  out  1  timeout expired before success
done  out  1  pass | fail

Behaviour:
- Reset (reset=0, async): state=RUN, FIFO empty, count=0, deq_valid=0, deq_adr=0, deq_data=0, overflow=0, pass=0, fail=0, done=0, cycle counter=0.
- States: RUN, PASS, FAIL. PASS and FAIL are terminal until reset.
- RUN: cycle counter increments each clock. Store captured when MemWrite=1 at rising edge.
- RUN->PASS: captured store with Adr==SUCCESS_ADR and WriteData==SUCCESS_DATA; pass=1 from the next cycle. Matching store is enqueued (if space).
- RUN->FAIL: counter reaches MAX_CYCLES-1 with no success that cycle; fail=1 next cycle. Success and timeout in the same cycle -> PASS wins.
- PASS/FAIL: no further captures; counter frozen; FIFO still drains.
- Enqueue latency: store at edge N visible at head (deq_valid=1) after edge N if FIFO was empty; count updates same edge.
- Dequeue: entry popped on rising edge when deq_valid & deq_ready. deq_adr/deq_data show head combinationally from storage; hold stable while deq_valid & !deq_ready.
- Full: capture without simultaneous pop is dropped; overflow set sticky; FIFO contents unchanged. Full with simultaneous pop: capture accepted, count unchanged.
- Empty: deq_ready ignored; count never underflows. Empty with capture and deq_ready same cycle: capture enqueued, no pop.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Dropped success store still triggers PASS (compare uses bus, not FIFO).
- Reset mid-operation: all state cleared immediately, in-flight stores discarded.
- Inputs X/Z are not checked in RTL.

Decomposition:
- Package store_trace_pkg: state enum (RUN, PASS, FAIL), default SUCCESS_ADR/SUCCESS_DATA constants, entry struct {adr[31:0], data[31:0]}.
- Sub-module store_fifo: DEPTH-parameterised synchronous FIFO with push/pop/full/empty/count, same clk/reset; monitor wraps it with capture gating, overflow flag, counter and FSM.

Test Plan:
- Reset then three stores (Adr 0x10/0x14/0x18, data 1/2/3), deq_ready=0 -> count=3, head 0x10/1; set deq_ready=1 -> pops in order over 3 cycles, deq_valid=0 after.
- Store Adr=100 data=8 -> pass=1, done=1 next cycle; later store Adr=0x20 not captured, count unchanged.
- Store Adr=100 data=7 only, MAX_CYCLES=50 -> fail=1 exactly 50 cycles after reset release, pass stays 0.
- DEPTH=8, nine stores with deq_ready=0 -> count=8, overflow=1, ninth entry absent; then store with deq_ready=1 while full -> accepted, count=8.
- Success store coincident with counter at MAX_CYCLES-1 -> pass=1, fail=0.
- Assert reset=0 mid-run with count=5, state RUN -> all outputs 0 immediately, after release count=0 and counter restarts.

Source files
------------

// File: rtl/store_trace_pkg.sv
// Shared types and default success constants for the store trace monitor.
package store_trace_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_t;

    localparam logic [31:0] DEF_SUCCESS_ADR  = 32'd100;
    localparam logic [31:0] DEF_SUCCESS_DATA = 32'd8;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } entry_t;

endpackage

// File: rtl/store_trace_monitor_if.sv
// Processor store bus, drain port and verdict flags of the store trace monitor.
interface store_trace_monitor_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          MemWrite;
    logic [31:0]   Adr;
    logic [31:0]   WriteData;
    logic          deq_ready;
    logic          deq_valid;
    logic [31:0]   deq_adr;
    logic [31:0]   deq_data;
    logic [CW-1:0] count;
    logic          overflow;
    logic          pass;
    logic          fail;
    logic          done;

    modport master (
        output MemWrite, Adr, WriteData, deq_ready,
        input  deq_valid, deq_adr, deq_data, count, overflow, pass, fail, done
    );

    modport slave (
        input  MemWrite, Adr, WriteData, deq_ready,
        output deq_valid, deq_adr, deq_data, count, overflow, pass, fail, done
    );

endinterface

// File: rtl/store_fifo.sv
// Synchronous FIFO of captured stores; occupancy counter separates full from empty.
module store_fifo
    import store_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_entry,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // a pop frees the slot this same edge, so a full FIFO can still accept
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_trace_monitor.sv
// Captures processor stores into a FIFO and decides pass (success store) or fail (timeout).
//   state | meaning
//   RUN   | capturing stores, cycle counter running
//   PASS  | success store seen; terminal until reset
//   FAIL  | timeout expired first; terminal until reset
module store_trace_monitor
    import store_trace_pkg::*;
#(
    parameter int          DEPTH        = 8,
    parameter logic [31:0] SUCCESS_ADR  = DEF_SUCCESS_ADR,
    parameter logic [31:0] SUCCESS_DATA = DEF_SUCCESS_DATA,
    parameter int          MAX_CYCLES   = 1000,
    parameter int          CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    store_trace_monitor_if.slave   bus
);
    localparam logic [1:0]       S_RUN  = RUN;
    localparam logic [1:0]       S_PASS = PASS;
    localparam logic [1:0]       S_FAIL = FAIL;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(MAX_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic             overflow;
    logic             capture;
    logic             success;
    logic             timeout;
    logic             pop;
    logic             full;
    logic             empty;
    entry_t           head;
    entry_t           cap_entry;

    assign capture   = bus.MemWrite && (state == S_RUN);
    // the verdict looks at the bus, so a success store dropped on overflow still passes
    assign success   = capture && (bus.Adr == SUCCESS_ADR) && (bus.WriteData == SUCCESS_DATA);
    assign timeout   = (state == S_RUN) && (cycle_cnt == CNT_TC);
    assign pop       = bus.deq_ready && !empty;
    assign cap_entry = '{adr: bus.Adr, data: bus.WriteData};

    store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (capture),
        .push_entry (cap_entry),
        .pop        (bus.deq_ready),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (bus.count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_RUN;
            cycle_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (capture && full && !pop) begin
                overflow <= 1'b1;
            end
            if (state == S_RUN) begin
                cycle_cnt <= cycle_cnt + 1'b1;
                if (success) begin
                    state <= S_PASS;
                end else if (timeout) begin
                    state <= S_FAIL;
                end
            end
        end
    end

    assign bus.deq_valid = !empty;
    assign bus.deq_adr   = empty ? '0 : head.adr;
    assign bus.deq_data  = empty ? '0 : head.data;
    assign bus.overflow  = overflow;
    assign bus.pass      = (state == S_PASS);
    assign bus.fail      = (state == S_FAIL);
    assign bus.done      = (state == S_PASS) || (state == S_FAIL);

endmodule

// File: tb/tb_store_trace_monitor.sv
// Directed and randomized check of store_trace_monitor against a queue-based reference model.
module tb_store_trace_monitor;
    import store_trace_pkg::*;

    localparam int DEPTH      = 8;
    localparam int MAX_CYCLES = 50;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    store_trace_monitor_if #(.DEPTH(DEPTH)) bus ();

    store_trace_monitor #(
        .DEPTH        (DEPTH),
        .SUCCESS_ADR  (32'd100),
        .SUCCESS_DATA (32'd8),
        .MAX_CYCLES   (MAX_CYCLES),
        .CNT_W        (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: queue of {adr,data}, sticky flags, count of RUN edges since reset
    logic [63:0] q [$];
    bit          m_ovf;
    bit          m_pass;
    bit          m_fail;
    int          m_edges;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf   = 1'b0;
        m_pass  = 1'b0;
        m_fail  = 1'b0;
        m_edges = 0;
    endtask

    task automatic model_edge();
        bit cap;
        bit hit;
        cap = bus.MemWrite && !(m_pass || m_fail);
        hit = cap && bus.Adr == 32'd100 && bus.WriteData == 32'd8;
        if (bus.deq_ready && q.size() > 0) void'(q.pop_front());
        if (cap) begin
            if (q.size() < DEPTH) q.push_back({bus.Adr, bus.WriteData});
            else                  m_ovf = 1'b1;
        end
        if (!(m_pass || m_fail)) begin
            m_edges++;
            if (hit)                          m_pass = 1'b1;
            else if (m_edges == MAX_CYCLES)   m_fail = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("count", 64'(bus.count), 64'(q.size()));
        chk("deq_valid", 64'(bus.deq_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("head_adr", 64'(bus.deq_adr), 64'(q[0][63:32]));
            chk("head_data", 64'(bus.deq_data), 64'(q[0][31:0]));
        end
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("pass", 64'(bus.pass), 64'(m_pass));
        chk("fail", 64'(bus.fail), 64'(m_fail));
        chk("done", 64'(bus.done), 64'(m_pass || m_fail));
    endtask

    task automatic cyc(input bit mw, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        bus.MemWrite  = mw;
        bus.Adr       = a;
        bus.WriteData = d;
        bus.deq_ready = rdy;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_clear();
        chk("rst_deq_adr", 64'(bus.deq_adr), 64'd0);
        chk("rst_deq_data", 64'(bus.deq_data), 64'd0);
        check_all();
        bus.MemWrite  = 1'b0;
        bus.Adr       = '0;
        bus.WriteData = '0;
        bus.deq_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic rand_run(input int cycles, input int rdy_pct);
        logic [31:0] a;
        logic [31:0] d;
        int          r;
        for (int i = 0; i < cycles; i++) begin
            r = $urandom_range(0, 29);
            if (r == 0) begin
                a = 32'd100; d = 32'd8;
            end else if (r == 1) begin
                a = 32'd100; d = $urandom_range(9, 255);
            end else begin
                a = $urandom; d = $urandom;
            end
            cyc($urandom_range(0, 2) != 0, a, d, $urandom_range(0, 99) < rdy_pct);
        end
    endtask

    initial begin
        bus.MemWrite  = 1'b0;
        bus.Adr       = '0;
        bus.WriteData = '0;
        bus.deq_ready = 1'b0;
        model_clear();

        // three stores, then drain in order; then success store ends capture
        do_reset();
        cyc(1, 32'h10, 32'd1, 0);
        cyc(1, 32'h14, 32'd2, 0);
        cyc(1, 32'h18, 32'd3, 0);
        chk("three_count", 64'(bus.count), 64'd3);
        chk("three_head", 64'(bus.deq_adr), 64'h10);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        chk("drained", 64'(bus.deq_valid), 64'd0);
        cyc(1, 32'd100, 32'd8, 0);
        chk("pass_next", 64'(bus.pass), 64'd1);
        cyc(1, 32'h20, 32'd5, 0);
        chk("no_capture_after_pass", 64'(bus.count), 64'd1);
        cyc(0, 0, 0, 1);

        // near-miss store only: fail exactly MAX_CYCLES edges after release
        do_reset();
        cyc(1, 32'd100, 32'd7, 0);
        for (int i = 1; i < MAX_CYCLES - 1; i++) cyc(0, 0, 0, 1);
        chk("fail_not_early", 64'(bus.fail), 64'd0);
        cyc(0, 0, 0, 1);
        chk("fail_at_max", 64'(bus.fail), 64'd1);
        chk("fail_no_pass", 64'(bus.pass), 64'd0);
        cyc(1, 32'h44, 32'd4, 0);

        // overflow: nine stores into eight slots, then push+pop while full
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1, 32'h100 + 32'(i * 4), 32'(i), 0);
        chk("ovf_count", 64'(bus.count), 64'd8);
        chk("ovf_flag", 64'(bus.overflow), 64'd1);
        cyc(1, 32'hAA, 32'hBB, 1);
        chk("full_pushpop_count", 64'(bus.count), 64'd8);
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1);

        // success store coincident with terminal count
        do_reset();
        for (int i = 0; i < MAX_CYCLES - 1; i++) cyc(0, 0, 0, 0);
        cyc(1, 32'd100, 32'd8, 0);
        chk("tie_pass", 64'(bus.pass), 64'd1);
        chk("tie_fail", 64'(bus.fail), 64'd0);

        // async reset in the middle of a run with five entries queued
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 32'h200 + 32'(i), 32'(i + 10), 0);
        chk("pre_reset_count", 64'(bus.count), 64'd5);
        #2;
        do_reset();
        for (int i = 0; i < MAX_CYCLES; i++) cyc(0, 0, 0, 0);
        chk("restart_fail", 64'(bus.fail), 64'd1);

        // randomized traffic against the model
        do_reset();
        rand_run(70, 25);
        do_reset();
        rand_run(70, 60);
        do_reset();
        rand_run(40, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
